mem_bus_responder: RTL

Memory-side responder for the CPU memory bus (`addr`, bidirectional `data`, `cs_input`, `we`, `oe`). It serves the fetch, load and store cycles issued by the CPU controller. Internally it holds 252 bytes of RAM at `0x00`–`0xFB` plus a memory-mapped I/O window at `0xFC`–`0xFF`. It adds a `ready` handshake with a configurable number of wait states, so the CPU FSM can stall on memory instead of relying on fixed clock counts.

---
 rtl/mem_bus_responder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - memory-side bus responder with RAM, I/O window and wait-state handshake
module mem_bus_responder #(
    parameter int         WAIT_STATES = 1,
    parameter logic [7:0] IO_BASE     = 8'hFC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] addr,
    inout  wire  [7:0] data,
    input  logic       cs_input,
    input  logic       we,
    input  logic       oe,
    output logic       ready,
    output logic [7:0] io_out,
    output logic       io_strobe,
    input  logic [7:0] io_in,
    output logic       bus_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam logic [2:0] WS        = 3'(WAIT_STATES);
    localparam int         RAM_DEPTH = int'(IO_BASE);

    logic [1:0] state;
    logic [2:0] wait_cnt;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       req_we;
    logic [7:0] rd_q;
    logic [7:0] mem [RAM_DEPTH];

    logic       is_ram;
    logic [1:0] io_sel;
    logic       mem_wr;

    // Decode of the latched request; the live bus is never used after the IDLE sample
    assign is_ram = req_addr < IO_BASE;
    assign io_sel = 2'(req_addr - IO_BASE);
    assign mem_wr = rst_n && (state == S_ACCESS) && req_we && is_ram;

    // Read data is only driven for a pure read; a write with oe set leaves the bus alone
    assign data = (cs_input && oe && !we) ? rd_q : 8'hzz;

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[req_addr] <= req_data;
        end
    end

    // Request FSM, completion pulse, I/O registers and error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= 3'd0;
            req_addr  <= 8'h00;
            req_data  <= 8'h00;
            req_we    <= 1'b0;
            ready     <= 1'b0;
            io_strobe <= 1'b0;
            io_out    <= 8'h00;
            bus_err   <= 1'b0;
            rd_q      <= 8'h00;
        end else begin
            ready     <= 1'b0;
            io_strobe <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cs_input) begin
                        req_addr <= addr;
                        req_we   <= we;
                        req_data <= data;
                        wait_cnt <= 3'd1;
                        state    <= (WS != 3'd0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (!cs_input) begin
                        state <= S_IDLE;
                    end else if (wait_cnt >= WS) begin
                        state <= S_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_ACCESS: begin
                    ready <= 1'b1;
                    state <= S_HOLD;
                    if (req_we) begin
                        if (!is_ram) begin
                            if (io_sel == 2'd0) begin
                                io_out    <= req_data;
                                io_strobe <= 1'b1;
                            end else begin
                                bus_err <= 1'b1;
                            end
                        end
                    end else begin
                        if (is_ram) begin
                            rd_q <= mem[req_addr];
                        end else begin
                            case (io_sel)
                                2'd0:    rd_q <= io_out;
                                2'd1:    rd_q <= io_in;
                                default: begin
                                    rd_q    <= 8'h00;
                                    bus_err <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_HOLD: begin
                    if (!cs_input) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
